axi_mem_arbiter: RTL and testbench

AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

---
 rtl/axi_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// Two AXI masters sharing one memory slave, with read and write paths arbitrated independently.
// Define ARB_RR_EN for round-robin contention; without it master 0 has fixed priority.
module axi_mem_arbiter #(
  parameter int DW = 128,
  parameter int AW = 32
) (
  input  logic            CLK,
  input  logic            RSTn,
  // master 0
  input  logic [AW-1:0]   S0_ARADDR,
  input  logic [7:0]      S0_ARLEN,
  input  logic [2:0]      S0_ARSIZE,
  input  logic [1:0]      S0_ARBURST,
  input  logic            S0_ARVALID,
  output logic            S0_ARREADY,
  output logic [DW-1:0]   S0_RDATA,
  output logic [1:0]      S0_RRESP,
  output logic            S0_RLAST,
  output logic            S0_RVALID,
  input  logic            S0_RREADY,
  input  logic [AW-1:0]   S0_AWADDR,
  input  logic [7:0]      S0_AWLEN,
  input  logic [2:0]      S0_AWSIZE,
  input  logic [1:0]      S0_AWBURST,
  input  logic            S0_AWVALID,
  output logic            S0_AWREADY,
  input  logic [DW-1:0]   S0_WDATA,
  input  logic [DW/8-1:0] S0_WSTRB,
  input  logic            S0_WLAST,
  input  logic            S0_WVALID,
  output logic            S0_WREADY,
  output logic [1:0]      S0_BRESP,
  output logic            S0_BVALID,
  input  logic            S0_BREADY,
  // master 1
  input  logic [AW-1:0]   S1_ARADDR,
  input  logic [7:0]      S1_ARLEN,
  input  logic [2:0]      S1_ARSIZE,
  input  logic [1:0]      S1_ARBURST,
  input  logic            S1_ARVALID,
  output logic            S1_ARREADY,
  output logic [DW-1:0]   S1_RDATA,
  output logic [1:0]      S1_RRESP,
  output logic            S1_RLAST,
  output logic            S1_RVALID,
  input  logic            S1_RREADY,
  input  logic [AW-1:0]   S1_AWADDR,
  input  logic [7:0]      S1_AWLEN,
  input  logic [2:0]      S1_AWSIZE,
  input  logic [1:0]      S1_AWBURST,
  input  logic            S1_AWVALID,
  output logic            S1_AWREADY,
  input  logic [DW-1:0]   S1_WDATA,
  input  logic [DW/8-1:0] S1_WSTRB,
  input  logic            S1_WLAST,
  input  logic            S1_WVALID,
  output logic            S1_WREADY,
  output logic [1:0]      S1_BRESP,
  output logic            S1_BVALID,
  input  logic            S1_BREADY,
  // memory slave
  output logic [AW-1:0]   MEM_ARADDR,
  output logic [7:0]      MEM_ARLEN,
  output logic [2:0]      MEM_ARSIZE,
  output logic [1:0]      MEM_ARBURST,
  output logic            MEM_ARVALID,
  input  logic            MEM_ARREADY,
  input  logic [DW-1:0]   MEM_RDATA,
  input  logic [1:0]      MEM_RRESP,
  input  logic            MEM_RLAST,
  input  logic            MEM_RVALID,
  output logic            MEM_RREADY,
  output logic [AW-1:0]   MEM_AWADDR,
  output logic [7:0]      MEM_AWLEN,
  output logic [2:0]      MEM_AWSIZE,
  output logic [1:0]      MEM_AWBURST,
  output logic            MEM_AWVALID,
  input  logic            MEM_AWREADY,
  output logic [DW-1:0]   MEM_WDATA,
  output logic [DW/8-1:0] MEM_WSTRB,
  output logic            MEM_WLAST,
  output logic            MEM_WVALID,
  input  logic            MEM_WREADY,
  input  logic [1:0]      MEM_BRESP,
  input  logic            MEM_BVALID,
  output logic            MEM_BREADY
);
  localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;

  logic [1:0] rd_state_reg, rd_state_next;
  logic [1:0] wr_state_reg, wr_state_next;
  logic       rd_owner_reg, wr_owner_reg;
  logic       rd_pick, wr_pick, rd_any, wr_any, rd_done, wr_done;
  logic       rd_in_addr, rd_in_data, wr_in_addr, wr_in_data, wr_in_resp;

  assign rd_any     = S0_ARVALID | S1_ARVALID;
  assign wr_any     = S0_AWVALID | S1_AWVALID;
  assign rd_in_addr = (rd_state_reg == R_ADDR);
  assign rd_in_data = (rd_state_reg == R_DATA);
  assign wr_in_addr = (wr_state_reg == W_ADDR);
  assign wr_in_data = (wr_state_reg == W_DATA);
  assign wr_in_resp = (wr_state_reg == W_RESP);
  assign rd_done    = rd_in_data & MEM_RVALID & MEM_RREADY & MEM_RLAST;
  assign wr_done    = wr_in_resp & MEM_BVALID & MEM_BREADY;

`ifdef ARB_RR_EN
  // Last-served master loses the next tie; reset value 1 lets master 0 win first.
  logic rd_last_reg, wr_last_reg;
  assign rd_pick = (S0_ARVALID & S1_ARVALID) ? ~rd_last_reg : S1_ARVALID;
  assign wr_pick = (S0_AWVALID & S1_AWVALID) ? ~wr_last_reg : S1_AWVALID;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_last_reg <= 1'b1;
      wr_last_reg <= 1'b1;
    end else begin
      if (rd_done) rd_last_reg <= rd_owner_reg;
      if (wr_done) wr_last_reg <= wr_owner_reg;
    end
  end
`else
  assign rd_pick = ~S0_ARVALID;
  assign wr_pick = ~S0_AWVALID;
`endif

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      R_IDLE:  if (rd_any) rd_state_next = R_ADDR;
      R_ADDR:  if (MEM_ARVALID & MEM_ARREADY) rd_state_next = R_DATA;
      R_DATA:  if (rd_done) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      W_IDLE:  if (wr_any) wr_state_next = W_ADDR;
      W_ADDR:  if (MEM_AWVALID & MEM_AWREADY) wr_state_next = W_DATA;
      W_DATA:  if (MEM_WVALID & MEM_WREADY & MEM_WLAST) wr_state_next = W_RESP;
      W_RESP:  if (wr_done) wr_state_next = W_IDLE;
      default: wr_state_next = W_IDLE;
    endcase
  end

  // Owner is captured only when leaving IDLE and held until the transaction completes.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_state_reg <= R_IDLE;
      wr_state_reg <= W_IDLE;
      rd_owner_reg <= 1'b0;
      wr_owner_reg <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      wr_state_reg <= wr_state_next;
      if (rd_state_reg == R_IDLE && rd_any) rd_owner_reg <= rd_pick;
      if (wr_state_reg == W_IDLE && wr_any) wr_owner_reg <= wr_pick;
    end
  end

  assign MEM_ARADDR  = rd_owner_reg ? S1_ARADDR  : S0_ARADDR;
  assign MEM_ARLEN   = rd_owner_reg ? S1_ARLEN   : S0_ARLEN;
  assign MEM_ARSIZE  = rd_owner_reg ? S1_ARSIZE  : S0_ARSIZE;
  assign MEM_ARBURST = rd_owner_reg ? S1_ARBURST : S0_ARBURST;
  assign MEM_ARVALID = rd_in_addr & (rd_owner_reg ? S1_ARVALID : S0_ARVALID);
  assign S0_ARREADY  = rd_in_addr & ~rd_owner_reg & MEM_ARREADY;
  assign S1_ARREADY  = rd_in_addr &  rd_owner_reg & MEM_ARREADY;

  assign S0_RDATA    = MEM_RDATA;
  assign S0_RRESP    = MEM_RRESP;
  assign S0_RLAST    = MEM_RLAST;
  assign S1_RDATA    = MEM_RDATA;
  assign S1_RRESP    = MEM_RRESP;
  assign S1_RLAST    = MEM_RLAST;
  assign S0_RVALID   = rd_in_data & ~rd_owner_reg & MEM_RVALID;
  assign S1_RVALID   = rd_in_data &  rd_owner_reg & MEM_RVALID;
  assign MEM_RREADY  = rd_in_data & (rd_owner_reg ? S1_RREADY : S0_RREADY);

  assign MEM_AWADDR  = wr_owner_reg ? S1_AWADDR  : S0_AWADDR;
  assign MEM_AWLEN   = wr_owner_reg ? S1_AWLEN   : S0_AWLEN;
  assign MEM_AWSIZE  = wr_owner_reg ? S1_AWSIZE  : S0_AWSIZE;
  assign MEM_AWBURST = wr_owner_reg ? S1_AWBURST : S0_AWBURST;
  assign MEM_AWVALID = wr_in_addr & (wr_owner_reg ? S1_AWVALID : S0_AWVALID);
  assign S0_AWREADY  = wr_in_addr & ~wr_owner_reg & MEM_AWREADY;
  assign S1_AWREADY  = wr_in_addr &  wr_owner_reg & MEM_AWREADY;

  assign MEM_WDATA   = wr_owner_reg ? S1_WDATA : S0_WDATA;
  assign MEM_WSTRB   = wr_owner_reg ? S1_WSTRB : S0_WSTRB;
  assign MEM_WLAST   = wr_owner_reg ? S1_WLAST : S0_WLAST;
  assign MEM_WVALID  = wr_in_data & (wr_owner_reg ? S1_WVALID : S0_WVALID);
  assign S0_WREADY   = wr_in_data & ~wr_owner_reg & MEM_WREADY;
  assign S1_WREADY   = wr_in_data &  wr_owner_reg & MEM_WREADY;

  assign S0_BRESP    = MEM_BRESP;
  assign S1_BRESP    = MEM_BRESP;
  assign S0_BVALID   = wr_in_resp & ~wr_owner_reg & MEM_BVALID;
  assign S1_BVALID   = wr_in_resp &  wr_owner_reg & MEM_BVALID;
  assign MEM_BREADY  = wr_in_resp & (wr_owner_reg ? S1_BREADY : S0_BREADY);
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed scoreboard bench for axi_mem_arbiter: memory slave model plus per-master expectation queues.
// Expected grant order follows ARB_RR_EN when the bench is built with it.
module tb_axi_mem_arbiter;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  logic [AW-1:0] S0_ARADDR, S1_ARADDR, S0_AWADDR, S1_AWADDR, MEM_ARADDR, MEM_AWADDR;
  logic [7:0]    S0_ARLEN, S1_ARLEN, S0_AWLEN, S1_AWLEN, MEM_ARLEN, MEM_AWLEN;
  logic [2:0]    S0_ARSIZE, S1_ARSIZE, S0_AWSIZE, S1_AWSIZE, MEM_ARSIZE, MEM_AWSIZE;
  logic [1:0]    S0_ARBURST, S1_ARBURST, S0_AWBURST, S1_AWBURST, MEM_ARBURST, MEM_AWBURST;
  logic          S0_ARVALID, S1_ARVALID, MEM_ARVALID, S0_ARREADY, S1_ARREADY, MEM_ARREADY;
  logic [DW-1:0] S0_RDATA, S1_RDATA, MEM_RDATA, S0_WDATA, S1_WDATA, MEM_WDATA;
  logic [1:0]    S0_RRESP, S1_RRESP, MEM_RRESP, S0_BRESP, S1_BRESP, MEM_BRESP;
  logic          S0_RLAST, S1_RLAST, MEM_RLAST, S0_RVALID, S1_RVALID, MEM_RVALID;
  logic          S0_RREADY, S1_RREADY, MEM_RREADY;
  logic          S0_AWVALID, S1_AWVALID, MEM_AWVALID, S0_AWREADY, S1_AWREADY, MEM_AWREADY;
  logic [SW-1:0] S0_WSTRB, S1_WSTRB, MEM_WSTRB;
  logic          S0_WLAST, S1_WLAST, MEM_WLAST, S0_WVALID, S1_WVALID, MEM_WVALID;
  logic          S0_WREADY, S1_WREADY, MEM_WREADY;
  logic          S0_BVALID, S1_BVALID, MEM_BVALID, S0_BREADY, S1_BREADY, MEM_BREADY;

  axi_mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARSIZE(S0_ARSIZE), .S0_ARBURST(S0_ARBURST),
    .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RLAST(S0_RLAST), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
    .S0_AWADDR(S0_AWADDR), .S0_AWLEN(S0_AWLEN), .S0_AWSIZE(S0_AWSIZE), .S0_AWBURST(S0_AWBURST),
    .S0_AWVALID(S0_AWVALID), .S0_AWREADY(S0_AWREADY),
    .S0_WDATA(S0_WDATA), .S0_WSTRB(S0_WSTRB), .S0_WLAST(S0_WLAST), .S0_WVALID(S0_WVALID), .S0_WREADY(S0_WREADY),
    .S0_BRESP(S0_BRESP), .S0_BVALID(S0_BVALID), .S0_BREADY(S0_BREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARSIZE(S1_ARSIZE), .S1_ARBURST(S1_ARBURST),
    .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RLAST(S1_RLAST), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
    .S1_AWADDR(S1_AWADDR), .S1_AWLEN(S1_AWLEN), .S1_AWSIZE(S1_AWSIZE), .S1_AWBURST(S1_AWBURST),
    .S1_AWVALID(S1_AWVALID), .S1_AWREADY(S1_AWREADY),
    .S1_WDATA(S1_WDATA), .S1_WSTRB(S1_WSTRB), .S1_WLAST(S1_WLAST), .S1_WVALID(S1_WVALID), .S1_WREADY(S1_WREADY),
    .S1_BRESP(S1_BRESP), .S1_BVALID(S1_BVALID), .S1_BREADY(S1_BREADY),
    .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN), .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST),
    .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
    .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST), .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY),
    .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN), .MEM_AWSIZE(MEM_AWSIZE), .MEM_AWBURST(MEM_AWBURST),
    .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
    .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST), .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
    .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } areq_t;
  typedef struct packed { logic m; logic [AW-1:0] addr; logic [7:0] len; } grant_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } rbeat_t;
  typedef struct packed { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } wbeat_t;

  areq_t  rd_pend0[$], rd_pend1[$], wr_pend0[$], wr_pend1[$];
  grant_t ar_exp[$], aw_exp[$];
  rbeat_t rexp0[$], rexp1[$];
  wbeat_t wq0[$], wq1[$], wexp0[$], wexp1[$];
  int bexp0, bexp1;
  int checks, errors;
  int wbeats_seen, stall_at, stall_left, wlast_cnt;

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a, input logic [7:0] b);
    return {a, 24'hA5A5A5, b, ~a, 24'h000000, b};
  endfunction

  // Memory slave model: read data derived from address and beat index, one B per WLAST.
  logic [AW-1:0] s_raddr;
  logic [7:0]    s_rlen, s_rbeat;
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      MEM_RVALID <= 1'b0; MEM_RLAST <= 1'b0; MEM_RDATA <= '0; MEM_BVALID <= 1'b0;
      s_raddr <= '0; s_rlen <= '0; s_rbeat <= '0;
    end else begin
      if (MEM_ARVALID && MEM_ARREADY) begin
        s_raddr <= MEM_ARADDR; s_rlen <= MEM_ARLEN; s_rbeat <= 8'd0;
        MEM_RVALID <= 1'b1; MEM_RDATA <= rd_word(MEM_ARADDR, 8'd0); MEM_RLAST <= (MEM_ARLEN == 8'd0);
      end else if (MEM_RVALID && MEM_RREADY) begin
        if (MEM_RLAST) MEM_RVALID <= 1'b0;
        else begin
          s_rbeat <= 8'(s_rbeat + 8'd1);
          MEM_RDATA <= rd_word(s_raddr, 8'(s_rbeat + 8'd1));
          MEM_RLAST <= (8'(s_rbeat + 8'd1) == s_rlen);
        end
      end
      if (MEM_WVALID && MEM_WREADY && MEM_WLAST) MEM_BVALID <= 1'b1;
      else if (MEM_BVALID && MEM_BREADY) MEM_BVALID <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic post_read(input logic m, input logic [AW-1:0] a, input logic [7:0] len);
    areq_t r;
    rbeat_t e;
    r.addr = a; r.len = len;
    if (m) rd_pend1.push_back(r); else rd_pend0.push_back(r);
    for (int b = 0; b <= int'(len); b++) begin
      e.data = rd_word(a, 8'(b)); e.last = (b == int'(len));
      if (m) rexp1.push_back(e); else rexp0.push_back(e);
    end
  endtask

  task automatic post_write(input logic m, input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [31:0] seed, input logic [SW-1:0] strb);
    areq_t r;
    wbeat_t w;
    r.addr = a; r.len = len;
    if (m) begin wr_pend1.push_back(r); bexp1++; end
    else begin wr_pend0.push_back(r); bexp0++; end
    for (int b = 0; b <= int'(len); b++) begin
      w.data = {seed, 32'(b), a, ~seed}; w.strb = strb; w.last = (b == int'(len));
      if (m) begin wq1.push_back(w); wexp1.push_back(w); end
      else begin wq0.push_back(w); wexp0.push_back(w); end
    end
  endtask

  task automatic expect_grant(input logic rd, input logic m, input logic [AW-1:0] a, input logic [7:0] len);
    grant_t g;
    g.m = m; g.addr = a; g.len = len;
    if (rd) ar_exp.push_back(g); else aw_exp.push_back(g);
  endtask

  task automatic drive();
    S0_ARVALID = (rd_pend0.size() > 0);
    if (rd_pend0.size() > 0) begin S0_ARADDR = rd_pend0[0].addr; S0_ARLEN = rd_pend0[0].len; end
    S1_ARVALID = (rd_pend1.size() > 0);
    if (rd_pend1.size() > 0) begin S1_ARADDR = rd_pend1[0].addr; S1_ARLEN = rd_pend1[0].len; end
    S0_AWVALID = (wr_pend0.size() > 0);
    if (wr_pend0.size() > 0) begin S0_AWADDR = wr_pend0[0].addr; S0_AWLEN = wr_pend0[0].len; end
    S1_AWVALID = (wr_pend1.size() > 0);
    if (wr_pend1.size() > 0) begin S1_AWADDR = wr_pend1[0].addr; S1_AWLEN = wr_pend1[0].len; end
    S0_WVALID = (wq0.size() > 0);
    if (wq0.size() > 0) {S0_WDATA, S0_WSTRB, S0_WLAST} = wq0[0];
    S1_WVALID = (wq1.size() > 0);
    if (wq1.size() > 0) {S1_WDATA, S1_WSTRB, S1_WLAST} = wq1[0];
  endtask

  function automatic bit all_empty();
    return rd_pend0.size() == 0 && rd_pend1.size() == 0 && wr_pend0.size() == 0 && wr_pend1.size() == 0 &&
           ar_exp.size() == 0 && aw_exp.size() == 0 && rexp0.size() == 0 && rexp1.size() == 0 &&
           wq0.size() == 0 && wq1.size() == 0 && wexp0.size() == 0 && wexp1.size() == 0 &&
           bexp0 == 0 && bexp1 == 0;
  endfunction

  // One clock: observe handshakes mid-cycle, then update master drives after the edge.
  task automatic tick();
    bit ar0, ar1, aw0, aw1, w0, w1;
    grant_t g;
    rbeat_t r;
    wbeat_t w;
    @(negedge CLK);
    ar0 = S0_ARVALID && S0_ARREADY; ar1 = S1_ARVALID && S1_ARREADY;
    aw0 = S0_AWVALID && S0_AWREADY; aw1 = S1_AWVALID && S1_AWREADY;
    w0  = S0_WVALID && S0_WREADY;   w1  = S1_WVALID && S1_WREADY;
    if (MEM_ARVALID && MEM_ARREADY) begin
      chk("ar_ready_onehot", S0_ARREADY ^ S1_ARREADY, 1);
      if (ar_exp.size() == 0) chk("ar_unexpected", 1, 0);
      else begin
        g = ar_exp.pop_front();
        chk("ar_grant", {S1_ARREADY, MEM_ARADDR, MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST},
                        {g.m, g.addr, g.len, 3'd4, 2'b01});
      end
    end
    if (MEM_AWVALID && MEM_AWREADY) begin
      chk("aw_ready_onehot", S0_AWREADY ^ S1_AWREADY, 1);
      if (aw_exp.size() == 0) chk("aw_unexpected", 1, 0);
      else begin
        g = aw_exp.pop_front();
        chk("aw_grant", {S1_AWREADY, MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST},
                        {g.m, g.addr, g.len, 3'd4, 2'b01});
      end
    end
    if (S0_RVALID || S1_RVALID) chk("r_onehot", S0_RVALID & S1_RVALID, 0);
    if (S0_RVALID && S0_RREADY) begin
      if (rexp0.size() == 0) chk("r0_unexpected", 1, 0);
      else begin r = rexp0.pop_front(); chk("r0_beat", {S0_RDATA, S0_RLAST, S0_RRESP}, {r.data, r.last, 2'b00}); end
    end
    if (S1_RVALID && S1_RREADY) begin
      if (rexp1.size() == 0) chk("r1_unexpected", 1, 0);
      else begin r = rexp1.pop_front(); chk("r1_beat", {S1_RDATA, S1_RLAST, S1_RRESP}, {r.data, r.last, 2'b00}); end
    end
    if (!MEM_WREADY) chk("w_backpressure", {S0_WREADY, S1_WREADY}, 2'b00);
    if (MEM_WVALID && MEM_WREADY) begin
      chk("w_ready_onehot", S0_WREADY ^ S1_WREADY, 1);
      if (MEM_WLAST) wlast_cnt++;
      if ((S1_WREADY ? wexp1.size() : wexp0.size()) == 0) chk("w_unexpected", 1, 0);
      else begin
        w = S1_WREADY ? wexp1.pop_front() : wexp0.pop_front();
        chk("w_beat", {MEM_WDATA, MEM_WSTRB, MEM_WLAST}, w);
      end
    end
    if (MEM_BVALID && MEM_BREADY) chk("b_route", S0_BVALID ^ S1_BVALID, 1);
    if (S0_BVALID && S0_BREADY) begin
      if (bexp0 == 0) chk("b0_unexpected", 1, 0);
      else begin bexp0--; chk("b0_resp", S0_BRESP, 2'b00); end
    end
    if (S1_BVALID && S1_BREADY) begin
      if (bexp1 == 0) chk("b1_unexpected", 1, 0);
      else begin bexp1--; chk("b1_resp", S1_BRESP, 2'b00); end
    end
    @(posedge CLK);
    #1;
    if (ar0) void'(rd_pend0.pop_front());
    if (ar1) void'(rd_pend1.pop_front());
    if (aw0) void'(wr_pend0.pop_front());
    if (aw1) void'(wr_pend1.pop_front());
    if (w0) void'(wq0.pop_front());
    if (w1) void'(wq1.pop_front());
    if (w0 || w1) wbeats_seen++;
    if (stall_left > 0 && wbeats_seen >= stall_at) begin MEM_WREADY = 1'b0; stall_left--; end
    else MEM_WREADY = 1'b1;
    drive();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!all_empty() && n < budget) begin tick(); n++; end
    chk(tag, all_empty(), 1);
  endtask

  function automatic logic [14:0] handshake_outs();
    return {S0_ARREADY, S0_RVALID, S0_AWREADY, S0_WREADY, S0_BVALID,
            S1_ARREADY, S1_RVALID, S1_AWREADY, S1_WREADY, S1_BVALID,
            MEM_ARVALID, MEM_RREADY, MEM_AWVALID, MEM_WVALID, MEM_BREADY};
  endfunction

  initial begin
    int n;
    int wl0;
    checks = 0; errors = 0; bexp0 = 0; bexp1 = 0;
    wbeats_seen = 0; stall_at = 0; stall_left = 0; wlast_cnt = 0;
    RSTn = 1'b0;
    {S0_ARSIZE, S1_ARSIZE, S0_AWSIZE, S1_AWSIZE} = {4{3'd4}};
    {S0_ARBURST, S1_ARBURST, S0_AWBURST, S1_AWBURST} = {4{2'b01}};
    {S0_ARADDR, S1_ARADDR, S0_AWADDR, S1_AWADDR} = '0;
    {S0_ARLEN, S1_ARLEN, S0_AWLEN, S1_AWLEN} = '0;
    {S0_WDATA, S1_WDATA, S0_WSTRB, S1_WSTRB, S0_WLAST, S1_WLAST} = '0;
    {S0_RREADY, S1_RREADY, S0_BREADY, S1_BREADY} = 4'hF;
    MEM_ARREADY = 1'b1; MEM_AWREADY = 1'b1; MEM_WREADY = 1'b1;
    MEM_RRESP = 2'b00; MEM_BRESP = 2'b00;
    drive();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs", handshake_outs(), 15'h0);
    RSTn = 1'b1;
    #1;
    chk("post_reset_idle", handshake_outs(), 15'h0);

    // Contention, first after reset: both masters queue two reads each.
    post_read(0, 32'h1000, 8'd1); post_read(0, 32'h1100, 8'd1);
    post_read(1, 32'h2000, 8'd1); post_read(1, 32'h2100, 8'd1);
`ifdef ARB_RR_EN
    expect_grant(1, 0, 32'h1000, 8'd1); expect_grant(1, 1, 32'h2000, 8'd1);
    expect_grant(1, 0, 32'h1100, 8'd1); expect_grant(1, 1, 32'h2100, 8'd1);
`else
    expect_grant(1, 0, 32'h1000, 8'd1); expect_grant(1, 0, 32'h1100, 8'd1);
    expect_grant(1, 1, 32'h2000, 8'd1); expect_grant(1, 1, 32'h2100, 8'd1);
`endif
    drive();
    wait_done("contention_done", 200);

    // Single read, 1-cycle grant latency, 4 beats to S0 only.
    post_read(0, 32'h100, 8'd3); expect_grant(1, 0, 32'h100, 8'd3);
    drive();
    #1;
    chk("grant_latency_idle", MEM_ARVALID, 1'b0);
    tick();
    chk("grant_latency_addr", {MEM_ARVALID, MEM_ARADDR}, {1'b1, 32'h100});
    wait_done("single_read_done", 50);

    // Back-to-back reads from S1: exactly one idle cycle between completion and next grant.
    post_read(1, 32'h400, 8'd0); post_read(1, 32'h500, 8'd0);
    expect_grant(1, 1, 32'h400, 8'd0); expect_grant(1, 1, 32'h500, 8'd0);
    drive();
    n = 0;
    while (rexp1.size() > 1 && n < 50) begin tick(); n++; end
    chk("b2b_idle_gap", MEM_ARVALID, 1'b0);
    tick();
    chk("b2b_regrant", {MEM_ARVALID, MEM_ARADDR}, {1'b1, 32'h500});
    wait_done("b2b_done", 50);

    // Concurrent S0 write and S1 read granted on the same edge.
    post_write(0, 32'h200, 8'd0, 32'hDEAD_BEEF, 16'hFFFF); expect_grant(0, 0, 32'h200, 8'd0);
    post_read(1, 32'h300, 8'd1); expect_grant(1, 1, 32'h300, 8'd1);
    drive();
    tick();
    chk("parallel_grant", {MEM_ARVALID, MEM_AWVALID}, 2'b11);
    wait_done("concurrent_done", 50);

    // S1 write with MEM_WREADY low for 3 cycles after the first beat.
    wl0 = wlast_cnt;
    post_write(1, 32'h600, 8'd3, 32'h1234_5678, 16'hF0F0); expect_grant(0, 1, 32'h600, 8'd3);
    stall_at = wbeats_seen + 1; stall_left = 3;
    drive();
    wait_done("backpressure_done", 60);
    chk("wlast_once", wlast_cnt - wl0, 1);
    chk("stall_consumed", stall_left, 0);

    // Reset after 2 of 4 read beats, then a fresh S1 read.
    post_read(0, 32'h700, 8'd3); expect_grant(1, 0, 32'h700, 8'd3);
    drive();
    n = 0;
    while (rexp0.size() > 2 && n < 50) begin tick(); n++; end
    chk("reset_beat2_reached", rexp0.size(), 2);
    RSTn = 1'b0;
    #1;
    chk("reset_mid_burst", handshake_outs(), 15'h0);
    rd_pend0.delete(); rexp0.delete(); ar_exp.delete();
    drive();
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    post_read(1, 32'h800, 8'd2); expect_grant(1, 1, 32'h800, 8'd2);
    drive();
    wait_done("post_reset_read_done", 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
